// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared port ids, default widths and helpers for the DMEM arbiter
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_WIDTH_DEF = 12;
    localparam int DMEM_DATA_WIDTH_DEF = 32;
    localparam int LOCK_MAX_DEF        = 16;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;

    function automatic port_e onehot_to_port(input logic [1:0] oh);
        return oh[1] ? PORT_DBG : PORT_CPU;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - combinational 2-way round-robin pick
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] eligible_i,
    input  port_e      last_winner_i,
    output logic [1:0] winner_o
);

    always_comb begin
        winner_o = 2'b00;
        unique case (eligible_i)
            2'b01:   winner_o = 2'b01;
            2'b10:   winner_o = 2'b10;
            // On a tie the port that did not win last time goes first
            2'b11:   winner_o = (last_winner_i == PORT_CPU) ? 2'b10 : 2'b01;
            default: winner_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin DMEM sharing between CPU and debug port with timed lock
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
    parameter int DMEM_DATA_WIDTH = DMEM_DATA_WIDTH_DEF,
    parameter int LOCK_MAX        = LOCK_MAX_DEF
) (
    input  logic                         sysclk_i,
    input  logic                         rst_ni,
    input  logic                         req0_i,
    input  logic                         req1_i,
    input  logic                         we0_i,
    input  logic                         we1_i,
    input  logic                         lock0_i,
    input  logic                         lock1_i,
    input  logic [DMEM_ADDR_WIDTH-1:0]   addr0_i,
    input  logic [DMEM_ADDR_WIDTH-1:0]   addr1_i,
    input  logic [DMEM_DATA_WIDTH-1:0]   wdata0_i,
    input  logic [DMEM_DATA_WIDTH-1:0]   wdata1_i,
    input  logic [DMEM_DATA_WIDTH/8-1:0] wstrb0_i,
    input  logic [DMEM_DATA_WIDTH/8-1:0] wstrb1_i,
    output logic                         gnt0_o,
    output logic                         gnt1_o,
    output logic                         rvalid0_o,
    output logic                         rvalid1_o,
    output logic [DMEM_DATA_WIDTH-1:0]   rdata0_o,
    output logic [DMEM_DATA_WIDTH-1:0]   rdata1_o,
    output logic                         lock_err0_o,
    output logic                         lock_err1_o,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [DMEM_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DMEM_DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DMEM_DATA_WIDTH/8-1:0] mem_wstrb_o,
    input  logic [DMEM_DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    // The timeout cycle is the last held cycle, i.e. the one whose increment would reach LOCK_MAX-1
    localparam logic [CW-1:0] TO_CNT = CW'(LOCK_MAX - 2);

    port_e          last_winner_q, last_winner_d;
    port_e          lock_owner_q, lock_owner_d;
    logic           lock_valid_q, lock_valid_d;
    logic [CW-1:0]  lock_cnt_q, lock_cnt_d;
    logic           rd_valid_q, rd_valid_d;
    port_e          rd_owner_q, rd_owner_d;

    logic [1:0] req;
    logic [1:0] owner_mask;
    logic [1:0] eligible;
    logic [1:0] winner;
    logic [1:0] gnt;
    logic       any_gnt;
    port_e      win_port;
    logic       win_we;
    logic       win_lock;
    logic       timeout;
    logic       release_c;
    logic       lock_err;

    assign req        = {req1_i, req0_i};
    assign owner_mask = (lock_owner_q == PORT_DBG) ? 2'b10 : 2'b01;
    assign eligible   = lock_valid_q ? (req & owner_mask) : req;

    rr_arb2 u_rr_arb2 (
        .eligible_i    (eligible),
        .last_winner_i (last_winner_q),
        .winner_o      (winner)
    );

    // No access may reach the RAM while reset is held
    assign gnt      = winner & {2{rst_ni}};
    assign any_gnt  = |gnt;
    assign win_port = onehot_to_port(gnt);
    assign win_we   = (win_port == PORT_DBG) ? we1_i : we0_i;
    assign win_lock = (win_port == PORT_DBG) ? lock1_i : lock0_i;

    assign gnt0_o = gnt[0];
    assign gnt1_o = gnt[1];

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        if (any_gnt) begin
            mem_en_o = 1'b1;
            mem_we_o = win_we;
            if (win_port == PORT_DBG) begin
                mem_addr_o  = addr1_i;
                mem_wdata_o = wdata1_i;
                mem_wstrb_o = wstrb1_i;
            end else begin
                mem_addr_o  = addr0_i;
                mem_wdata_o = wdata0_i;
                mem_wstrb_o = wstrb0_i;
            end
        end
    end

    // While locked only the owner can be granted, so any grant is an owner access
    assign timeout   = lock_valid_q && (lock_cnt_q == TO_CNT);
    assign release_c = lock_valid_q && any_gnt && !win_lock;
    assign lock_err  = timeout && !release_c;

    assign lock_err0_o = lock_err && (lock_owner_q == PORT_CPU);
    assign lock_err1_o = lock_err && (lock_owner_q == PORT_DBG);

    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        if (!lock_valid_q) begin
            if (any_gnt && win_lock) begin
                lock_valid_d = 1'b1;
                lock_owner_d = win_port;
                lock_cnt_d   = '0;
            end
        end else if (release_c || timeout) begin
            lock_valid_d = 1'b0;
            lock_cnt_d   = '0;
        end else if (any_gnt && win_lock) begin
            lock_cnt_d = '0;
        end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
    end

    assign last_winner_d = any_gnt ? win_port : last_winner_q;
    assign rd_valid_d    = any_gnt && !win_we;
    assign rd_owner_d    = win_port;

    always_ff @(posedge sysclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_winner_q <= PORT_DBG;
            lock_owner_q  <= PORT_CPU;
            lock_valid_q  <= 1'b0;
            lock_cnt_q    <= '0;
            rd_valid_q    <= 1'b0;
            rd_owner_q    <= PORT_CPU;
        end else begin
            last_winner_q <= last_winner_d;
            lock_owner_q  <= lock_owner_d;
            lock_valid_q  <= lock_valid_d;
            lock_cnt_q    <= lock_cnt_d;
            rd_valid_q    <= rd_valid_d;
            rd_owner_q    <= rd_owner_d;
        end
    end

    assign rvalid0_o = rd_valid_q && (rd_owner_q == PORT_CPU);
    assign rvalid1_o = rd_valid_q && (rd_owner_q == PORT_DBG);
    assign rdata0_o  = rvalid0_o ? mem_rdata_i : '0;
    assign rdata1_o  = rvalid1_o ? mem_rdata_i : '0;

endmodule
